// File: rtl/ram_port_arbiter.sv
// Four-requester round-robin arbiter in front of a single-port RAM.
// Clears the whole RAM after reset, then serialises one read or write at a time.
module ram_port_arbiter #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          req,
    input  logic [3:0]          we_req,
    input  logic [4*AW-1:0]     addr_req,
    input  logic [4*DW-1:0]     wdata_req,
    output logic [3:0]          gnt,
    output logic [1:0]          rid,
    output logic [DW-1:0]       rdata,
    output logic                rvalid,
    output logic [AW-1:0]       ram_addr,
    output logic [DW-1:0]       ram_data,
    output logic                ram_we,
    input  logic [DW-1:0]       ram_q,
    output logic                init_done
);

    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned CW    = AW + 1;

    typedef enum logic [1:0] {
        S_INIT   = 2'd0,
        S_IDLE   = 2'd1,
        S_ACCESS = 2'd2,
        S_RDWAIT = 2'd3
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic [1:0]      r_last, w_last_nxt;
    logic [1:0]      r_sel, w_sel_nxt;
    logic [1:0]      w_sel;
    logic            w_hit;
    logic [3:0]      w_gnt_nxt;
    logic [1:0]      w_rid_nxt;
    logic [DW-1:0]   w_rdata_nxt;
    logic            w_rvalid_nxt;
    logic [AW-1:0]   w_addr_nxt;
    logic [DW-1:0]   w_data_nxt;
    logic            w_we_nxt;
    logic            w_done_nxt;

    // Round-robin pick: first requester at or after last-granted+1.
    always_comb begin
        w_sel = r_last;
        w_hit = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (!w_hit && req[2'(r_last + 2'(k))]) begin
                w_hit = 1'b1;
                w_sel = 2'(r_last + 2'(k));
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_last_nxt   = r_last;
        w_sel_nxt    = r_sel;
        w_gnt_nxt    = 4'b0000;
        w_rid_nxt    = rid;
        w_rdata_nxt  = rdata;
        w_rvalid_nxt = 1'b0;
        w_addr_nxt   = ram_addr;
        w_data_nxt   = ram_data;
        w_we_nxt     = 1'b0;
        w_done_nxt   = init_done;
        case (r_state)
            S_INIT: begin
                // The counter runs one past the last address so the write to the top word completes first.
                if (r_cnt == CW'(DEPTH)) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_we_nxt   = 1'b1;
                    w_data_nxt = '0;
                    w_addr_nxt = AW'(r_cnt);
                    w_cnt_nxt  = r_cnt + CW'(1);
                end
            end
            S_IDLE: begin
                if (w_hit) begin
                    w_gnt_nxt   = 4'b0001 << w_sel;
                    w_last_nxt  = w_sel;
                    w_sel_nxt   = w_sel;
                    w_addr_nxt  = addr_req[32'(w_sel) * AW +: AW];
                    w_data_nxt  = wdata_req[32'(w_sel) * DW +: DW];
                    w_we_nxt    = we_req[w_sel];
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                // ram_we still reflects the granted command type here.
                w_state_nxt = ram_we ? S_IDLE : S_RDWAIT;
            end
            S_RDWAIT: begin
                w_rdata_nxt  = ram_q;
                w_rid_nxt    = r_sel;
                w_rvalid_nxt = 1'b1;
                w_state_nxt  = S_IDLE;
            end
            default: w_state_nxt = S_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_INIT;
            r_cnt     <= '0;
            r_last    <= 2'd3;
            r_sel     <= 2'd0;
            gnt       <= 4'b0000;
            rid       <= 2'd0;
            rdata     <= '0;
            rvalid    <= 1'b0;
            ram_addr  <= '0;
            ram_data  <= '0;
            ram_we    <= 1'b0;
            init_done <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_last    <= w_last_nxt;
            r_sel     <= w_sel_nxt;
            gnt       <= w_gnt_nxt;
            rid       <= w_rid_nxt;
            rdata     <= w_rdata_nxt;
            rvalid    <= w_rvalid_nxt;
            ram_addr  <= w_addr_nxt;
            ram_data  <= w_data_nxt;
            ram_we    <= w_we_nxt;
            init_done <= w_done_nxt;
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: RAM behavioural model plus a transaction-level
// reference (round-robin order, shadow memory, 2/3-cycle command costs).
module tb_ram_port_arbiter;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 6;
    localparam int unsigned DEPTH = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        req, we_req;
    logic [4*AW-1:0]   addr_req;
    logic [4*DW-1:0]   wdata_req;
    logic [3:0]        gnt;
    logic [1:0]        rid;
    logic [DW-1:0]     rdata;
    logic              rvalid;
    logic [AW-1:0]     ram_addr;
    logic [DW-1:0]     ram_data;
    logic              ram_we;
    logic [DW-1:0]     ram_q;
    logic              init_done;

    logic [DW-1:0]     ram [DEPTH];
    bit                do_fill;
    int                checks, failures;

    // reference model state
    int                m_wait;
    bit                m_rd_pend;
    logic [1:0]        m_last, m_rd_rid;
    logic [DW-1:0]     m_rd_data;
    logic [DW-1:0]     m_mem [DEPTH];
    logic [3:0]        exp_gnt;
    logic              exp_rvalid, exp_we;
    logic [1:0]        exp_rid;
    logic [DW-1:0]     exp_rdata, exp_data;
    logic [AW-1:0]     exp_addr;

    always #5 clk = ~clk;

    ram_port_arbiter #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst), .req(req), .we_req(we_req), .addr_req(addr_req),
        .wdata_req(wdata_req), .gnt(gnt), .rid(rid), .rdata(rdata), .rvalid(rvalid),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we), .ram_q(ram_q),
        .init_done(init_done)
    );

    always @(posedge clk) begin
        if (do_fill) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= DW'($urandom_range(1, 255));
        end else if (ram_we) begin
            ram[ram_addr] <= ram_data;
        end
        ram_q <= ram[ram_addr];
    end

    task automatic set_tx(input int i, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[i] = 1'b1;
        we_req[i] = we;
        addr_req[i*AW +: AW] = a;
        wdata_req[i*DW +: DW] = d;
    endtask

    task automatic model_reset();
        m_wait = 0; m_rd_pend = 0; m_last = 2'd3;
        exp_rid = 2'd0; exp_rdata = '0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    endtask

    // Predicts what the next clock edge produces from the current requests.
    task automatic model_edge();
        exp_gnt = 4'b0000; exp_rvalid = 1'b0; exp_we = 1'b0;
        if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0 && m_rd_pend) begin
                exp_rvalid = 1'b1; exp_rid = m_rd_rid; exp_rdata = m_rd_data; m_rd_pend = 0;
            end
        end else if (req != 4'b0000) begin
            int s;
            s = int'(m_last);
            do s = (s + 1) % 4; while (!req[s]);
            m_last   = 2'(s);
            exp_gnt  = 4'(1 << s);
            exp_we   = we_req[s];
            exp_addr = addr_req[s*AW +: AW];
            exp_data = wdata_req[s*DW +: DW];
            if (exp_we) begin
                m_mem[exp_addr] = exp_data; m_wait = 1;
            end else begin
                m_rd_pend = 1; m_rd_rid = 2'(s); m_rd_data = m_mem[exp_addr]; m_wait = 2;
            end
        end
    endtask

    task automatic edge_step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic retire();
        for (int i = 0; i < 4; i++) if (exp_gnt[i]) req[i] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; req = '0; we_req = '0; addr_req = '0; wdata_req = '0; do_fill = 1'b1;
        @(negedge clk);
        @(negedge clk);
        do_fill = 1'b0;
        set_tx(1, 1'b0, AW'(5), '0);
        #1;
        checks++;
        if ({gnt, rid, rdata, rvalid, ram_addr, ram_data, ram_we} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got gnt=%b rid=%0d rdata=%h rvalid=%b addr=%h data=%h we=%b exp all zero",
                     gnt, rid, rdata, rvalid, ram_addr, ram_data, ram_we);
        end
        checks++;
        if (init_done !== 1'b0) begin
            failures++; $display("FAIL reset_init_done got=%b exp=0", init_done);
        end
    endtask

    task automatic test_init(input bit pend);
        int nz;
        rst = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            @(negedge clk);
            checks++;
            if (ram_we !== 1'b1 || ram_addr !== AW'(k) || ram_data !== '0 || gnt !== 4'b0000 || init_done !== 1'b0) begin
                failures++;
                $display("FAIL init_seq k=%0d got we=%b addr=%0d data=%h gnt=%b done=%b exp we=1 addr=%0d data=0 gnt=0 done=0",
                         k, ram_we, ram_addr, ram_data, gnt, init_done, k);
            end
        end
        @(negedge clk);
        checks++;
        if (init_done !== 1'b1 || ram_we !== 1'b0 || gnt !== 4'b0000) begin
            failures++;
            $display("FAIL init_done got done=%b we=%b gnt=%b exp done=1 we=0 gnt=0", init_done, ram_we, gnt);
        end
        nz = 0;
        for (int i = 0; i < DEPTH; i++) if (ram[i] !== '0) nz++;
        checks++;
        if (nz != 0) begin
            failures++; $display("FAIL init_cleared got nonzero_words=%0d exp=0", nz);
        end
        model_reset();
        if (pend) begin
            for (int c = 0; c < 4; c++) begin
                edge_step();
                if (c == 0) begin
                    checks++;
                    if (gnt !== 4'b0010) begin
                        failures++; $display("FAIL init_pending_grant got=%b exp=0010", gnt);
                    end
                end
                checks++;
                if (rvalid !== exp_rvalid || rid !== exp_rid || rdata !== exp_rdata) begin
                    failures++;
                    $display("FAIL init_pending_read c=%0d got rvalid=%b rid=%0d rdata=%h exp rvalid=%b rid=%0d rdata=%h",
                             c, rvalid, rid, rdata, exp_rvalid, exp_rid, exp_rdata);
                end
                retire();
            end
        end
    endtask

    task automatic test_write_read();
        set_tx(2, 1'b1, AW'('h10), DW'('hA5));
        for (int c = 0; c < 2; c++) begin
            edge_step();
            checks++;
            if (gnt !== exp_gnt || ram_we !== exp_we) begin
                failures++; $display("FAIL wr_cycle c=%0d got gnt=%b we=%b exp gnt=%b we=%b", c, gnt, ram_we, exp_gnt, exp_we);
            end
            if (c == 0) begin
                checks++;
                if (gnt !== 4'b0100 || ram_addr !== AW'('h10) || ram_data !== DW'('hA5)) begin
                    failures++; $display("FAIL wr_grant got gnt=%b addr=%h data=%h exp 0100 10 a5", gnt, ram_addr, ram_data);
                end
            end
            retire();
        end
        set_tx(2, 1'b0, AW'('h10), '0);
        for (int c = 0; c < 4; c++) begin
            edge_step();
            checks++;
            if (gnt !== exp_gnt || rvalid !== exp_rvalid || rid !== exp_rid || rdata !== exp_rdata) begin
                failures++;
                $display("FAIL rd_cycle c=%0d got gnt=%b rvalid=%b rid=%0d rdata=%h exp gnt=%b rvalid=%b rid=%0d rdata=%h",
                         c, gnt, rvalid, rid, rdata, exp_gnt, exp_rvalid, exp_rid, exp_rdata);
            end
            if (c == 0) begin
                checks++;
                if (gnt !== 4'b0100) begin
                    failures++; $display("FAIL rd_grant got=%b exp=0100", gnt);
                end
            end
            if (c == 2) begin
                checks++;
                if (rvalid !== 1'b1 || rid !== 2'd2 || rdata !== DW'('hA5)) begin
                    failures++; $display("FAIL rd_return got rvalid=%b rid=%0d rdata=%h exp 1 2 a5", rvalid, rid, rdata);
                end
            end
            retire();
        end
    endtask

    task automatic test_all_readers();
        logic [3:0] seq [5];
        int n;
        logic [3:0] want;
        set_tx(3, 1'b1, AW'('h20), DW'('h3C));
        for (int c = 0; c < 2; c++) begin
            edge_step();
            retire();
        end
        for (int i = 0; i < 4; i++) set_tx(i, 1'b0, AW'('h20 + i), '0);
        n = 0;
        for (int c = 0; c < 15; c++) begin
            edge_step();
            checks++;
            if (gnt !== exp_gnt || rvalid !== exp_rvalid || rid !== exp_rid || rdata !== exp_rdata) begin
                failures++;
                $display("FAIL all_rd c=%0d got gnt=%b rvalid=%b rid=%0d rdata=%h exp gnt=%b rvalid=%b rid=%0d rdata=%h",
                         c, gnt, rvalid, rid, rdata, exp_gnt, exp_rvalid, exp_rid, exp_rdata);
            end
            if (gnt != 4'b0000 && n < 5) begin
                seq[n] = gnt; n++;
            end
            for (int i = 0; i < 4; i++) if (exp_gnt[i]) set_tx(i, 1'b0, AW'($urandom_range(0, DEPTH - 1)), '0);
        end
        req = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            want = 4'(1 << (k % 4));
            checks++;
            if (k >= n || seq[k] !== want) begin
                failures++; $display("FAIL rotate k=%0d got=%b exp=%b", k, (k < n) ? seq[k] : 4'bxxxx, want);
            end
        end
    endtask

    task automatic test_rr_wrap();
        set_tx(0, 1'b1, AW'('h01), DW'('h11));
        for (int c = 0; c < 2; c++) begin
            edge_step();
            retire();
        end
        set_tx(3, 1'b0, AW'('h20), '0);
        set_tx(0, 1'b0, AW'('h01), '0);
        for (int c = 0; c < 6; c++) begin
            edge_step();
            checks++;
            if (gnt !== exp_gnt || rvalid !== exp_rvalid || rid !== exp_rid || rdata !== exp_rdata) begin
                failures++;
                $display("FAIL rr_wrap c=%0d got gnt=%b rvalid=%b rid=%0d rdata=%h exp gnt=%b rvalid=%b rid=%0d rdata=%h",
                         c, gnt, rvalid, rid, rdata, exp_gnt, exp_rvalid, exp_rid, exp_rdata);
            end
            if (c == 0 || c == 3) begin
                checks++;
                if (gnt !== ((c == 0) ? 4'b1000 : 4'b0001)) begin
                    failures++; $display("FAIL rr_order c=%0d got=%b exp=%b", c, gnt, (c == 0) ? 4'b1000 : 4'b0001);
                end
            end
            retire();
        end
    endtask

    task automatic test_reset_rdwait();
        set_tx(1, 1'b0, AW'('h10), '0);
        edge_step();
        checks++;
        if (gnt !== 4'b0010) begin
            failures++; $display("FAIL rdwait_grant got=%b exp=0010", gnt);
        end
        retire();
        @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({gnt, rid, rdata, rvalid, ram_addr, ram_data, ram_we, init_done} !== '0) begin
            failures++;
            $display("FAIL async_reset got gnt=%b rid=%0d rdata=%h rvalid=%b addr=%h data=%h we=%b done=%b exp all zero",
                     gnt, rid, rdata, rvalid, ram_addr, ram_data, ram_we, init_done);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (rvalid !== 1'b0) begin
            failures++; $display("FAIL aborted_rvalid got=%b exp=0", rvalid);
        end
    endtask

    task automatic test_random();
        int ngrant [4];
        for (int i = 0; i < 4; i++) ngrant[i] = 0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 4; i++)
                if (!req[i] && $urandom_range(0, 2) == 0)
                    set_tx(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom));
            edge_step();
            checks++;
            if (gnt !== exp_gnt || ram_we !== exp_we || rvalid !== exp_rvalid || rid !== exp_rid || rdata !== exp_rdata) begin
                failures++;
                $display("FAIL random c=%0d got gnt=%b we=%b rvalid=%b rid=%0d rdata=%h exp gnt=%b we=%b rvalid=%b rid=%0d rdata=%h",
                         c, gnt, ram_we, rvalid, rid, rdata, exp_gnt, exp_we, exp_rvalid, exp_rid, exp_rdata);
            end
            if (exp_gnt != 4'b0000) begin
                checks++;
                if (ram_addr !== exp_addr || ram_data !== exp_data) begin
                    failures++;
                    $display("FAIL random_cmd c=%0d got addr=%h data=%h exp addr=%h data=%h", c, ram_addr, ram_data, exp_addr, exp_data);
                end
                for (int i = 0; i < 4; i++) if (exp_gnt[i]) ngrant[i]++;
            end
            retire();
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ngrant[i] == 0) begin
                failures++; $display("FAIL starvation req=%0d got grants=0 exp >0", i);
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_init(1'b1);
        test_write_read();
        test_all_readers();
        test_rr_wrap();
        test_reset_rdwait();
        test_init(1'b0);
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
